// File: rtl/axis_rr_arbiter.sv
// Two-input round-robin AXI-Stream arbiter with packet/burst-length grant holding
// and a single registered output stage.
module axis_rr_arbiter #(
  parameter int DATA_WD   = 64,
  parameter int BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s00_axis_tvalid,
  input  logic [DATA_WD-1:0] s00_axis_tdata,
  input  logic               s00_axis_tlast,
  output logic               s00_axis_tready,
  input  logic               s01_axis_tvalid,
  input  logic [DATA_WD-1:0] s01_axis_tdata,
  input  logic               s01_axis_tlast,
  output logic               s01_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [1:0]         grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_t             state, state_nxt;
  logic               last_gnt, last_gnt_nxt;
  logic [7:0]         beat_cnt;
  logic               valid_reg;
  logic [DATA_WD-1:0] data_reg;
  logic               last_reg;
  logic               out_rdy;
  logic               sel_valid;
  logic [DATA_WD-1:0] sel_data;
  logic               sel_last;
  logic               accept;

  assign out_rdy         = !valid_reg || m_axis_tready;
  assign s00_axis_tready = (state == GNT0) && out_rdy;
  assign s01_axis_tready = (state == GNT1) && out_rdy;
  assign grant           = {state == GNT1, state == GNT0};
  assign m_axis_tvalid   = valid_reg;
  assign m_axis_tdata    = data_reg;
  assign m_axis_tlast    = last_reg;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    case (state)
      GNT0: begin
        sel_valid = s00_axis_tvalid;
        sel_data  = s00_axis_tdata;
        sel_last  = s00_axis_tlast;
      end
      GNT1: begin
        sel_valid = s01_axis_tvalid;
        sel_data  = s01_axis_tdata;
        sel_last  = s01_axis_tlast;
      end
      default: ;
    endcase
  end

  assign accept = sel_valid && out_rdy;

  // Contention goes to whichever source was not served last.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid && (!s01_axis_tvalid || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (s01_axis_tvalid) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (accept && (sel_last || beat_cnt == BURST_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Grants are only entered from IDLE, so holding the count at zero there clears it per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (out_rdy) begin
      valid_reg <= sel_valid;
      if (state != IDLE) begin
        data_reg <= sel_data;
        last_reg <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: a directed vector table, scripted corner
// cases and randomized traffic, all checked against a queue-based reference model.
module tb_axis_rr_arbiter;

  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic          v1;
    logic [DW-1:0] d1;
    logic          l1;
    logic [1:0]    g;
    logic          tr1;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s00v, s00l, s01v, s01l, mr;
  logic [DW-1:0] s00d, s01d;

  logic          a_s00r, a_s01r, a_mv, a_ml;
  logic [DW-1:0] a_md;
  logic [1:0]    a_g;
  logic          b_s00r, b_s01r, b_mv, b_ml;
  logic [DW-1:0] b_md;
  logic [1:0]    b_g;

  logic          sel;
  logic          obs_s00r, obs_s01r, obs_mv, obs_ml;
  logic [DW-1:0] obs_md;
  logic [1:0]    obs_g;

  beat_t q0[$];
  beat_t q1[$];
  beat_t mq[$];

  int   checks = 0;
  int   errors = 0;
  int   m_owner;
  int   m_cnt;
  int   m_burst;
  logic m_last;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_WD(DW), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .s00_axis_tvalid(s00v), .s00_axis_tdata(s00d), .s00_axis_tlast(s00l), .s00_axis_tready(a_s00r),
    .s01_axis_tvalid(s01v), .s01_axis_tdata(s01d), .s01_axis_tlast(s01l), .s01_axis_tready(a_s01r),
    .m_axis_tvalid(a_mv), .m_axis_tdata(a_md), .m_axis_tlast(a_ml), .m_axis_tready(mr),
    .grant(a_g)
  );

  axis_rr_arbiter #(.DATA_WD(DW), .BURST_LEN(3)) dut_burst (
    .clk(clk), .rst(rst),
    .s00_axis_tvalid(s00v), .s00_axis_tdata(s00d), .s00_axis_tlast(s00l), .s00_axis_tready(b_s00r),
    .s01_axis_tvalid(s01v), .s01_axis_tdata(s01d), .s01_axis_tlast(s01l), .s01_axis_tready(b_s01r),
    .m_axis_tvalid(b_mv), .m_axis_tdata(b_md), .m_axis_tlast(b_ml), .m_axis_tready(mr),
    .grant(b_g)
  );

  always_comb begin
    obs_s00r = sel ? b_s00r : a_s00r;
    obs_s01r = sel ? b_s01r : a_s01r;
    obs_mv   = sel ? b_mv   : a_mv;
    obs_md   = sel ? b_md   : a_md;
    obs_ml   = sel ? b_ml   : a_ml;
    obs_g    = sel ? b_g    : a_g;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    s00v = 1'b0; s00d = '0; s00l = 1'b0;
    s01v = 1'b0; s01d = '0; s01l = 1'b0;
    mr   = 1'b1;
    q0.delete();
    q1.delete();
    mq.delete();
    m_owner = -1;
    m_last  = 1'b1;
    m_cnt   = 0;
    m_burst = sel ? 3 : 16;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addPacket(input int src, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + DW'(i);
      b.last = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // The output register behaves as a one-deep FIFO of accepted beats (mq).
  task automatic checkOutput();
    logic full, rdy;
    full = (mq.size() > 0);
    rdy  = !full || mr;
    chk("grant", 64'(obs_g), (m_owner == 0) ? 64'd1 : (m_owner == 1) ? 64'd2 : 64'd0);
    chk("s00_tready", 64'(obs_s00r), 64'((m_owner == 0) && rdy));
    chk("s01_tready", 64'(obs_s01r), 64'((m_owner == 1) && rdy));
    chk("m_tvalid", 64'(obs_mv), 64'(full));
    if (full) begin
      chk("m_tdata", obs_md, mq[0].data);
      chk("m_tlast", 64'(obs_ml), 64'(mq[0].last));
    end
  endtask

  task automatic applyStimulus(input logic hold0, input logic hold1, input logic mr_in);
    logic  full, rdy, acc0, acc1;
    beat_t b;
    @(negedge clk);
    s00v = (q0.size() > 0) && !hold0;
    s01v = (q1.size() > 0) && !hold1;
    s00d = '0; s00l = 1'b0;
    s01d = '0; s01l = 1'b0;
    if (s00v) begin s00d = q0[0].data; s00l = q0[0].last; end
    if (s01v) begin s01d = q1[0].data; s01l = q1[0].last; end
    mr = mr_in;
    #1;
    checkOutput();
    full = (mq.size() > 0);
    rdy  = !full || mr;
    acc0 = s00v && (m_owner == 0) && rdy;
    acc1 = s01v && (m_owner == 1) && rdy;
    if (full && mr) b = mq.pop_front();
    if (acc0 || acc1) begin
      b = acc0 ? q0.pop_front() : q1.pop_front();
      mq.push_back(b);
      m_cnt++;
      if (b.last || m_cnt == m_burst) m_owner = -1;
    end else if (m_owner == -1) begin
      if (s00v && (!s01v || m_last)) begin
        m_owner = 0; m_last = 1'b0; m_cnt = 0;
      end else if (s01v) begin
        m_owner = 1; m_last = 1'b1; m_cnt = 0;
      end
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc;
    logic mrpat[10];

    sel = 1'b0;
    doReset();

    // Reset values
    #1;
    chk("rst_grant", 64'(a_g), 64'd0);
    chk("rst_s00_tready", 64'(a_s00r), 64'd0);
    chk("rst_s01_tready", 64'(a_s01r), 64'd0);
    chk("rst_m_tvalid", 64'(a_mv), 64'd0);
    chk("rst_m_tdata", a_md, 64'd0);
    chk("rst_m_tlast", 64'(a_ml), 64'd0);

    // Single-source 4-beat packet from s01
    vecs[0] = '{1'b1, 64'h10, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0};
    vecs[1] = '{1'b1, 64'h10, 1'b0, 2'b10, 1'b1, 1'b0, 64'h0,  1'b0};
    vecs[2] = '{1'b1, 64'h11, 1'b0, 2'b10, 1'b1, 1'b1, 64'h10, 1'b0};
    vecs[3] = '{1'b1, 64'h12, 1'b0, 2'b10, 1'b1, 1'b1, 64'h11, 1'b0};
    vecs[4] = '{1'b1, 64'h13, 1'b1, 2'b10, 1'b1, 1'b1, 64'h12, 1'b0};
    vecs[5] = '{1'b0, 64'h0,  1'b0, 2'b00, 1'b0, 1'b1, 64'h13, 1'b1};
    vecs[6] = '{1'b0, 64'h0,  1'b0, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s00v = 1'b0;
      s01v = vecs[i].v1; s01d = vecs[i].d1; s01l = vecs[i].l1;
      mr   = 1'b1;
      #1;
      chk("vec_grant", 64'(a_g), 64'(vecs[i].g));
      chk("vec_s01_tready", 64'(a_s01r), 64'(vecs[i].tr1));
      chk("vec_s00_tready", 64'(a_s00r), 64'd0);
      chk("vec_m_tvalid", 64'(a_mv), 64'(vecs[i].mv));
      if (vecs[i].mv) begin
        chk("vec_m_tdata", a_md, vecs[i].md);
        chk("vec_m_tlast", 64'(a_ml), 64'(vecs[i].ml));
      end
    end

    // Contention: both sources stream 2-beat packets
    doReset();
    for (int k = 0; k < 4; k++) begin
      addPacket(0, 2, 64'hA0 + 64'(2 * k));
      addPacket(1, 2, 64'hB0 + 64'(2 * k));
    end
    repeat (26) applyStimulus(1'b0, 1'b0, 1'b1);

    // Back-pressure on a 4-beat s00 packet
    doReset();
    addPacket(0, 4, 64'h60);
    mrpat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, mrpat[i]);

    // Granted s00 stalls for 5 cycles while s01 waits
    doReset();
    addPacket(0, 4, 64'h70);
    addPacket(1, 2, 64'h80);
    for (int i = 0; i < 18; i++) applyStimulus(i >= 3 && i < 8, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with s00 granted and an output beat registered
    doReset();
    addPacket(0, 4, 64'h90);
    addPacket(1, 4, 64'hC0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_m_tvalid", 64'(a_mv), 64'd0);
    chk("async_s00_tready", 64'(a_s00r), 64'd0);
    chk("async_s01_tready", 64'(a_s01r), 64'd0);
    chk("async_grant", 64'(a_g), 64'd0);
    doReset();
    addPacket(0, 2, 64'h90);
    addPacket(1, 2, 64'hC0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    chk("post_reset_grant", 64'(a_g), 64'd1);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);

    // Burst limit of 3 splits a 5-beat packet
    sel = 1'b1;
    doReset();
    addPacket(0, 5, 64'h50);
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);

    // Randomized traffic on both burst configurations
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      doReset();
      for (int k = 0; k < 30; k++) begin
        addPacket(0, int'($urandom_range(1, 6)), {8'h00, 56'(k << 4)});
        addPacket(1, int'($urandom_range(1, 6)), {8'h01, 56'(k << 4)});
      end
      cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0 || mq.size() > 0) && cyc < 3000) begin
        applyStimulus(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0);
        cyc++;
      end
      chk("random_drain", 64'(q0.size() + q1.size() + mq.size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Two-input round-robin arbiter that merges two AXI-Stream frame sources onto one shared downstream channel. It is the converging counterpart to the datapath fork stage. A grant is held for a whole packet (up to `tlast`), or until a configurable burst limit is reached, so frames from one source are not interleaved beat-by-beat. The output is a single register stage with the same ready/valid pass-through as the other stream stages in the datapath.

## Interface
- `DATA_WD`, 64, width of `tdata` on all ports.
- `BURST_LEN`, 16, maximum beats per grant. Legal range 1..255.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s00_axis_tvalid`  in  1  source 0 valid.
- `s00_axis_tdata`  in  DATA_WD  source 0 data.
- `s00_axis_tlast`  in  1  source 0 end of packet.
- `s00_axis_tready`  out  1  source 0 ready.
- `s01_axis_tvalid` / `s01_axis_tdata` / `s01_axis_tlast` / `s01_axis_tready`: same as source 0, for source 1.
- `m_axis_tvalid`  out  1  merged valid.
- `m_axis_tdata`  out  DATA_WD  merged data.
- `m_axis_tlast`  out  1  merged end of packet.
- `m_axis_tready`  in  1  downstream ready.
- `grant`  out  2  one-hot current owner: bit0 = s00, bit1 = s01, 00 = idle.

## Operation
- **FSM states:** IDLE, GNT0, GNT1. `grant` = {state==GNT1, state==GNT0}.
- **IDLE arbitration:**
  - Only s00 valid -> GNT0.
  - Only s01 valid -> GNT1.
  - Both valid -> the source not equal to `last_gnt`.
  - Neither valid -> stay in IDLE.
- **`last_gnt` register:** 1 bit, reset 1, so s00 wins the first contention. Loaded with the granted index on entering GNTx.
- **Ready:**
  - `sXX_axis_tready = (state==GNTxx) & (!valid_reg | m_axis_tready)`.
  - The non-granted source's tready is 0.
  - Both readies are 0 in IDLE.
- **Output stage:** when `!valid_reg | m_axis_tready`:
  - `valid_reg <= granted tvalid & in GNTx`.
  - `data_reg`/`last_reg` load the granted source's `tdata`/`tlast`.
  - Otherwise all three hold.
  - `m_axis_*` are driven directly from these registers.
- **Beat counter:**
  - 8-bit `beat_cnt`, cleared to 0 on every transition into GNTx.
  - Increments on each accepted beat (granted tvalid & tready).
- **Release:** on an accepted beat with `tlast`=1, or with `beat_cnt == BURST_LEN-1`, the state goes to IDLE at that edge.
- **Granted source drops tvalid mid-grant:** hold the grant indefinitely. There is no timeout.
- **Burst-limit release:** may split a packet. The remainder re-arbitrates normally. `m_axis_tlast` is passed through unmodified and is never synthesized.

## Timing
- **Reset values:**
  - state = IDLE, `last_gnt` = 1, `beat_cnt` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0.
  - `s00_axis_tready` = `s01_axis_tready` = 0, `grant` = 00.
- **Arbitration latency:** a source valid in IDLE at edge N gets `grant` and tready after edge N. Its first beat can be accepted at edge N+1.
- **Data latency:** a beat accepted at edge N appears on `m_axis_*` after edge N. Downstream can take it at edge N+1.
- **Throughput:**
  - 1 beat/cycle within a grant while `m_axis_tready`=1.
  - Exactly one idle cycle (IDLE state) between consecutive grants.
- **Back-pressure:** with `valid_reg`=1 and `m_axis_tready`=0, both readies are 0 and output data must be stable.
- **Simultaneous last beat and new request:** the grant returns to IDLE first. The alternate source is chosen in the following cycle.
- **Mid-operation reset:** asynchronous assertion immediately forces all reset values, dropping any registered beat. Deassertion resumes from IDLE with `last_gnt` = 1.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with s00 granted and `valid_reg`=1 -> `m_axis_tvalid`, both readies and `grant` go to 0 without a clock edge. After release, the first grant goes to s00 when both sources are valid.
- **Single source:** s01 sends a 4-beat packet (data 0x10..0x13, tlast on the last beat) with `m_axis_tready`=1 -> `grant`=10 one cycle after valid, 4 consecutive output beats 0x10..0x13, `m_axis_tlast` on 0x13, then `grant`=00.
- **Contention:** both sources continuously send 2-beat packets (s00: 0xA*, s01: 0xB*) -> output order A,A,B,B,A,A... with one bubble between grants and `tlast` on every second beat.
- **Burst limit:** `BURST_LEN`=3, s00 sends a 5-beat packet with s01 idle -> grant released after beat 3, then re-granted to s00 after one IDLE cycle. Beats 4-5 follow, and `tlast` appears only on beat 5.
- **Back-pressure:** toggle `m_axis_tready` 1,0,0,1 during a 4-beat s00 packet -> no beat lost or duplicated, output held stable while tready=0, s00 tready=0 on exactly those cycles.
- **Stall:** the granted s00 drops tvalid for 5 cycles mid-packet while s01 is valid -> `grant` stays 01, and s01 tready stays 0 until s00's tlast beat plus the IDLE cycle.
